// File: rtl/sm83_dbg_uart.sv
// Host-side UART bridge for the sm83 debug byte link: 8N1 serial <-> toggle-sequence handshakes.
// Define SM83_DBG_UART_PARITY_EN for 8E1 frames and the sticky parity_err output.
module sm83_dbg_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] data_rx,
    output logic       data_rx_valid,
    output logic       data_rx_seq,
    input  logic       data_rx_ack,
    input  logic [7:0] data_tx,
    input  logic       data_tx_seq,
    output logic       data_tx_ack,
    input  logic       clr_err,
`ifdef SM83_DBG_UART_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    output logic       frame_err
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    // Line synchroniser plus one extra stage for falling-edge detection
    logic rxd_meta, rxd_sync, rxd_prev;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    rx_state_t     rx_state, rx_state_nxt;
    logic [CW-1:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]    rx_bit, rx_bit_nxt;
    logic [7:0]    rx_shift, rx_shift_nxt;
    logic          rx_good_c, rx_ferr_c, rx_busy_c;
`ifdef SM83_DBG_UART_PARITY_EN
    logic          rx_par, rx_par_nxt;
    logic          rx_perr_c;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
`ifdef SM83_DBG_UART_PARITY_EN
            rx_par   <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
`ifdef SM83_DBG_UART_PARITY_EN
            rx_par   <= rx_par_nxt;
`endif
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + CW'(1);
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_good_c    = 1'b0;
        rx_ferr_c    = 1'b0;
`ifdef SM83_DBG_UART_PARITY_EN
        rx_par_nxt   = rx_par;
        rx_perr_c    = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rxd_prev && !rxd_sync) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_bit_nxt   = '0;
                    rx_state_nxt = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rxd_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
`ifdef SM83_DBG_UART_PARITY_EN
                        rx_state_nxt = RX_PARITY;
`else
                        rx_state_nxt = RX_STOP;
`endif
                    end
                end
            end
`ifdef SM83_DBG_UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_par_nxt   = rxd_sync;
                    rx_state_nxt = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rxd_sync) begin
                        rx_state_nxt = RX_IDLE;
`ifdef SM83_DBG_UART_PARITY_EN
                        if (rx_par != ^rx_shift) rx_perr_c = 1'b1;
                        else                     rx_good_c = 1'b1;
`else
                        rx_good_c = 1'b1;
`endif
                    end else begin
                        rx_ferr_c    = 1'b1;
                        rx_state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                rx_cnt_nxt = '0;
                if (rxd_sync) rx_state_nxt = RX_IDLE;
            end
            default: begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign rx_busy_c = (data_rx_seq != data_rx_ack);

    // Delivery into the holding register and sticky error flags (a new error beats clr_err)
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data_rx       <= '0;
            data_rx_seq   <= 1'b0;
            data_rx_valid <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
`ifdef SM83_DBG_UART_PARITY_EN
            parity_err    <= 1'b0;
`endif
        end else begin
            if (rx_good_c && !rx_busy_c) begin
                data_rx       <= rx_shift;
                data_rx_seq   <= ~data_rx_seq;
                data_rx_valid <= 1'b1;
            end else begin
                data_rx_valid <= rx_busy_c;
            end
            overrun   <= (rx_good_c && rx_busy_c) || (overrun && !clr_err);
            frame_err <= rx_ferr_c || (frame_err && !clr_err);
`ifdef SM83_DBG_UART_PARITY_EN
            parity_err <= rx_perr_c || (parity_err && !clr_err);
`endif
        end
    end

    tx_state_t     tx_state, tx_state_nxt;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]    tx_bit, tx_bit_nxt;
    logic [7:0]    tx_shift, tx_shift_nxt;
    logic          txd_nxt, tx_load_c, tx_pend_c;
`ifdef SM83_DBG_UART_PARITY_EN
    logic          tx_par;
`endif

    assign tx_pend_c = (data_tx_seq != data_tx_ack);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            uart_txd    <= 1'b1;
            data_tx_ack <= 1'b0;
`ifdef SM83_DBG_UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            uart_txd <= txd_nxt;
            if (tx_load_c) begin
                data_tx_ack <= data_tx_seq;
`ifdef SM83_DBG_UART_PARITY_EN
                tx_par      <= ^data_tx;
`endif
            end
        end
    end

    // txd is registered from the next-state view so each bit holds exactly CLKS_PER_BIT cycles
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + CW'(1);
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        txd_nxt      = uart_txd;
        tx_load_c    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                txd_nxt    = 1'b1;
                tx_load_c  = tx_pend_c;
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_bit_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                    txd_nxt      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt = '0;
                    if (tx_bit == 3'd7) begin
`ifdef SM83_DBG_UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
                        txd_nxt      = tx_par;
`else
                        tx_state_nxt = TX_STOP;
                        txd_nxt      = 1'b1;
`endif
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        txd_nxt      = tx_shift[1];
                    end
                end
            end
`ifdef SM83_DBG_UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_STOP;
                    txd_nxt      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                    txd_nxt      = 1'b1;
                    tx_load_c    = tx_pend_c;
                end
            end
            default: begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
        endcase
        if (tx_load_c) begin
            tx_state_nxt = TX_START;
            tx_cnt_nxt   = '0;
            tx_shift_nxt = data_tx;
            txd_nxt      = 1'b0;
        end
    end

endmodule

// File: tb/tb_sm83_dbg_uart.sv
// Directed bench for sm83_dbg_uart: RX vector table plus hand-written TX, reset and parity sequences.
module tb_sm83_dbg_uart;

    localparam int unsigned CPB = 16;
`ifdef SM83_DBG_UART_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif

    logic       clk = 1'b0;
    logic       nreset;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] data_rx;
    logic       data_rx_valid;
    logic       data_rx_seq;
    logic       data_rx_ack;
    logic [7:0] data_tx;
    logic       data_tx_seq;
    logic       data_tx_ack;
    logic       clr_err;
    logic       overrun;
    logic       frame_err;
`ifdef SM83_DBG_UART_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    sm83_dbg_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .uart_rxd      (uart_rxd),
        .uart_txd      (uart_txd),
        .data_rx       (data_rx),
        .data_rx_valid (data_rx_valid),
        .data_rx_seq   (data_rx_seq),
        .data_rx_ack   (data_rx_ack),
        .data_tx       (data_tx),
        .data_tx_seq   (data_tx_seq),
        .data_tx_ack   (data_tx_ack),
        .clr_err       (clr_err),
`ifdef SM83_DBG_UART_PARITY_EN
        .parity_err    (parity_err),
`endif
        .overrun       (overrun),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic        do_ack;
        logic        do_clr;
        logic        do_rst;
        int unsigned idle;
        logic [7:0]  e_data;
        logic        e_seq;
        logic        e_valid;
        logic        e_ovr;
        logic        e_ferr;
    } rx_vec_t;

    localparam int NV = 7;
    rx_vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SM83_DBG_UART_PARITY_EN
        uart_rxd = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
    endtask

    function automatic logic [10:0] tx_frame(input logic [7:0] b);
`ifdef SM83_DBG_UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    logic [10:0] f1, f2;
    logic        exp_bit;

    initial begin
        //            byte   stop  ack   clr   rst   idle data   seq   valid ovr   ferr
        vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hCB, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'hCB, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h37, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hCB, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hB8, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h23, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hB8, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1, 8'h18, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};

        nreset      = 1'b0;
        uart_rxd    = 1'b1;
        data_rx_ack = 1'b0;
        data_tx     = 8'h00;
        data_tx_seq = 1'b0;
        clr_err     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd",   32'(uart_txd),      32'd1);
        chk("rst_data",  32'(data_rx),       32'h0);
        chk("rst_valid", 32'(data_rx_valid), 32'd0);
        chk("rst_seq",   32'(data_rx_seq),   32'd0);
        chk("rst_txack", 32'(data_tx_ack),   32'd0);
        chk("rst_ovr",   32'(overrun),       32'd0);
        chk("rst_ferr",  32'(frame_err),     32'd0);
        nreset = 1'b1;

        // RX vectors; b2b frames use idle=0 so the next start bit follows the stop bit directly
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].do_ack) begin
                data_rx_ack = data_rx_seq;
                @(negedge clk);
                chk($sformatf("v%0d_ack_valid", i), 32'(data_rx_valid), 32'd0);
            end
            if (vecs[i].do_clr) begin
                clr_err = 1'b1;
                @(negedge clk);
                clr_err = 1'b0;
            end
            if (vecs[i].do_rst) begin
                nreset      = 1'b0;
                data_rx_ack = 1'b0;
                @(negedge clk);
                nreset = 1'b1;
            end
            uart_rxd = 1'b1;
            repeat (vecs[i].idle * CPB) @(negedge clk);
            send_frame(vecs[i].b, vecs[i].stop);
            chk($sformatf("v%0d_data", i),  32'(data_rx),       32'(vecs[i].e_data));
            chk($sformatf("v%0d_seq", i),   32'(data_rx_seq),   32'(vecs[i].e_seq));
            chk($sformatf("v%0d_valid", i), 32'(data_rx_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_ovr", i),   32'(overrun),       32'(vecs[i].e_ovr));
            chk($sformatf("v%0d_ferr", i),  32'(frame_err),     32'(vecs[i].e_ferr));
        end
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // TX: 0xF9, then 0x5A offered mid-frame must follow with no idle gap
        f1 = tx_frame(8'hF9);
        f2 = tx_frame(8'h5A);
        data_tx     = 8'hF9;
        data_tx_seq = 1'b1;
        for (int c = 0; c < int'(2 * NB * CPB); c++) begin
            @(negedge clk);
            if (c == 0) chk("tx_ack1", 32'(data_tx_ack), 32'd1);
            if (c == int'(NB * CPB) - 1) chk("tx_ack_held", 32'(data_tx_ack), 32'd1);
            if (c == int'(NB * CPB)) chk("tx_ack2", 32'(data_tx_ack), 32'd0);
            if ((c % CPB) == 0 || (c % CPB) == CPB - 1) begin
                exp_bit = (c < int'(NB * CPB)) ? f1[c / CPB] : f2[c / CPB - NB];
                chk($sformatf("tx_bit_c%0d", c), 32'(uart_txd), 32'(exp_bit));
            end
            if (c == 40) begin
                data_tx     = 8'h5A;
                data_tx_seq = 1'b0;
            end
        end
        @(negedge clk);
        chk("tx_idle", 32'(uart_txd), 32'd1);

        // Reset in the middle of both an RX frame and a TX frame
        data_tx     = 8'h81;
        data_tx_seq = 1'b1;
        uart_rxd    = 1'b0;
        repeat (2 * CPB + 5) @(negedge clk);
        chk("mid_txd", 32'(uart_txd), 32'd0);
        nreset      = 1'b0;
        data_tx_seq = 1'b0;
        data_rx_ack = 1'b0;
        uart_rxd    = 1'b1;
        #1;
        chk("arst_txd",   32'(uart_txd),      32'd1);
        chk("arst_valid", 32'(data_rx_valid), 32'd0);
        chk("arst_data",  32'(data_rx),       32'h0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("post_rst_seq",   32'(data_rx_seq),   32'd0);
        chk("post_rst_valid", 32'(data_rx_valid), 32'd0);
        chk("post_rst_txd",   32'(uart_txd),      32'd1);
        send_frame(8'h5C, 1'b1);
        chk("clean_data",  32'(data_rx),       32'h5C);
        chk("clean_seq",   32'(data_rx_seq),   32'd1);
        chk("clean_valid", 32'(data_rx_valid), 32'd1);

`ifdef SM83_DBG_UART_PARITY_EN
        data_rx_ack = 1'b1;
        uart_rxd    = 1'b1;
        repeat (CPB) @(negedge clk);
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        par_flip = 1'b0;
        chk("par_err",   32'(parity_err),  32'd1);
        chk("par_seq",   32'(data_rx_seq), 32'd1);
        chk("par_data",  32'(data_rx),     32'h5C);
        chk("par_ferr",  32'(frame_err),   32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
        chk("par_clr", 32'(parity_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sm83_dbg_uart.md
Name: sm83_dbg_uart

Overview:
Host-side end of the sm83 debug byte link, i.e. the counterpart of the debug interface's data_rx/data_tx ports. Deserialises 8N1 UART bytes from the host into the toggle-sequence rx handshake (drives data_rx/data_rx_valid/data_rx_seq, watches data_rx_ack). Accepts bytes from the debug interface via the tx toggle handshake (watches data_tx/data_tx_seq, drives data_tx_ack) and serialises them onto the UART line. Sits between the FPGA pin pair and sm83_dbg_ifc.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 4..65535.

Ports:
clk  input  1  system clock, all logic on posedge
nreset  input  1  asynchronous, active-low reset
uart_rxd  input  1  serial line from host, idle high, asynchronous to clk
uart_txd  output  1  serial line to host, idle high
data_rx  output  8  byte toward debug interface
data_rx_valid  output  1  high while a delivered byte is unacknowledged
data_rx_seq  output  1  toggles once per delivered byte
data_rx_ack  input  1  debug interface copies data_rx_seq here when the byte is consumed
data_tx  input  8  byte from debug interface
data_tx_seq  input  1  debug interface toggles to offer a new byte
data_tx_ack  output  1  set equal to data_tx_seq when the byte is latched
clr_err  input  1  synchronous clear of the sticky error flags
overrun  output  1  sticky: a received byte was dropped because the previous one was still pending
frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (nreset low, async): uart_txd=1, data_rx=0, data_rx_valid=0, data_rx_seq=0, data_tx_ack=0, overrun=0, frame_err=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts the frame; there is no partial delivery or transmission.
- uart_rxd passes through a 2-flop synchroniser (reset value 1) before any use.
- RX FSM: IDLE -> START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2 (integer divide). If the line is still low, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, into a shift register. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT.
    - Sample high: valid byte.
    - Sample low: set frame_err, discard the byte, wait in BREAK until the line is high, then go to IDLE.
- Valid byte delivery:
  - Holding register free (data_rx_ack == data_rx_seq): on the next edge, data_rx <= byte, data_rx_seq toggles, data_rx_valid <= 1.
  - Holding register occupied: set overrun and drop the byte; data_rx is unchanged.
- data_rx_valid = (data_rx_seq != data_rx_ack), registered, so it falls one cycle after ack matches. data_rx stays stable while valid is high.
- After the stop sample the RX FSM returns to IDLE immediately, so back-to-back frames with one stop bit are received.
- TX FSM: IDLE -> START when data_tx_seq != data_tx_ack.
  - In the same edge: latch data_tx and set data_tx_ack <= data_tx_seq.
  - Line sequence: START (txd=0), DATA (8 bits LSB first), STOP (txd=1). Each bit lasts exactly CLKS_PER_BIT cycles. Then IDLE.
  - A new seq toggle during a frame is held until IDLE. Back-to-back frames have no extra idle bit.
- data_tx_seq/data_tx_ack are treated as same-clock signals; no synchroniser.
- clr_err clears overrun and frame_err. If clr_err coincides with a new error event, the error wins (flag stays 1).
- Bit counters are wide enough for CLKS_PER_BIT-1 and never wrap mid-bit.

Optional Feature:
SM83_DBG_UART_PARITY_EN:
- When defined, both directions use 8E1: an even parity bit is inserted between D7 and the stop bit.
- RX checks parity. On mismatch it sets the sticky output parity_err and discards the byte; no delivery and no seq toggle.
- clr_err also clears parity_err.
- When undefined, frames are 8N1 and the parity_err port does not exist.

Test Plan:
- Reset, then host sends 0x3C at CLKS_PER_BIT=16 -> 16*9.5 cycles later data_rx=0x3C, data_rx_seq 0->1, data_rx_valid=1. Bench drives ack=1 -> valid=0 next cycle.
- Host sends 0xCB then 0x37 back-to-back, no ack -> data_rx=0xCB, seq toggled once, overrun=1. After ack and clr_err: overrun=0; next byte 0xB8 is delivered with seq=0.
- Frame with stop bit low (0x23) -> frame_err=1, seq unchanged. Line returns high; 0x18 is then received correctly.
- Bench toggles data_tx_seq with data_tx=0xF9 -> data_tx_ack follows next edge. uart_txd shows 0, 1,0,0,1,1,1,1,1, 1, each bit 16 cycles.
- Second toggle with 0x5A issued mid-frame -> ack is delayed until the first stop bit ends, then 0x5A frame follows with no idle gap.
- nreset asserted mid-RX frame and mid-TX frame -> uart_txd=1 immediately, no delivery. Next clean frame is received normally. With SM83_DBG_UART_PARITY_EN, a wrong parity bit on 0x01 -> parity_err=1 and no delivery.
